mii_phy_frame_source: RTL and testbench

- PHY-side MII frame generator: turns AXI-Stream byte frames into the receive nibble stream a PHY presents to a MAC's MII receiver (rxd/rx_dv/rx_er).
- Adds preamble, SFD, optional zero padding and CRC-32 FCS, then enforces an inter-frame gap.
- Used in loopback rigs and on-chip MAC receive-path test harnesses. `clk` is the MII receive clock: one nibble per cycle.

---
 rtl/mii_pkg.sv | 21 ++
 rtl/AXIS_IF.sv | 23 ++
 rtl/crc32_nibble.sv | 22 ++
 rtl/mii_phy_frame_source.sv | 243 ++++++++++++++++++++++++
 tb/tb_mii_phy_frame_source.sv | 340 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mii_pkg.sv
// Shared constants and state type for the MII frame source.
// Intended for reuse by a future MII frame checker.
package mii_pkg;

   localparam logic [3:0]  MII_PREAMBLE_NIBBLE = 4'h5;
   localparam logic [3:0]  MII_SFD_HI          = 4'hD;
   localparam logic [31:0] CRC32_POLY          = 32'hEDB88320;
   localparam logic [31:0] CRC32_INIT          = 32'hFFFFFFFF;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PREAMBLE,
      ST_SFD,
      ST_DATA,
      ST_PAD,
      ST_FCS,
      ST_IFG,
      ST_DROP
   } mii_src_state_t;

endpackage

// File: rtl/AXIS_IF.sv
// Byte-wide AXI-Stream bundle with tlast/tuser.
// Transmitter drives the beat, Receiver returns tready.
interface AXIS_IF #(
   parameter int TDATA_WIDTH = 8
);

   logic                   tvalid;
   logic                   tready;
   logic [TDATA_WIDTH-1:0] tdata;
   logic                   tlast;
   logic                   tuser;

   modport Transmitter (
      output tvalid, tdata, tlast, tuser,
      input  tready
   );

   modport Receiver (
      input  tvalid, tdata, tlast, tuser,
      output tready
   );

endinterface

// File: rtl/crc32_nibble.sv
// Next Ethernet CRC-32 state after shifting in one nibble, lsb first.
// Purely combinational.
module crc32_nibble
   import mii_pkg::*;
(
   input  logic [3:0]  data_i,
   input  logic [31:0] crc_i,
   output logic [31:0] crc_o
);

   logic [31:0] c;

   always_comb begin
      c = crc_i;
      for (int i = 0; i < 4; i++) begin
         if (c[0] ^ data_i[i]) c = (c >> 1) ^ CRC32_POLY;
         else                  c = c >> 1;
      end
      crc_o = c;
   end

endmodule

// File: rtl/mii_phy_frame_source.sv
// PHY-side MII receive nibble generator: preamble, SFD, data,
// zero padding, FCS, then an enforced inter-frame gap.
module mii_phy_frame_source
   import mii_pkg::*;
#(
   parameter bit ENABLE_PADDING   = 1'b1,
   parameter int MIN_FRAME_LENGTH = 64,
   parameter int PREAMBLE_NIBBLES = 15
) (
   input  logic       clk,
   input  logic       reset_n,
   AXIS_IF.Receiver   s_axis_if,
   output logic [3:0] mii_rxd,
   output logic       mii_rx_dv,
   output logic       mii_rx_er,
   input  logic [7:0] cfg_ifg,
   input  logic       cfg_enable,
   output logic       busy,
   output logic       frame_done,
   output logic       underflow
);

   localparam logic [8:0] PAD_LEN = 9'(MIN_FRAME_LENGTH - 4);
   localparam logic [8:0] PRE_LEN = 9'(PREAMBLE_NIBBLES);

   mii_src_state_t state_q, state_d;
   logic [8:0]  cnt_q, cnt_d;
   logic [7:0]  bytes_q, bytes_d;
   logic [7:0]  data_q, data_d;
   logic        last_q, last_d;
   logic        bad_q, bad_d;
   logic        hi_q, hi_d;
   logic [31:0] crc_q, crc_d;
   logic [3:0]  rxd_q, rxd_d;
   logic        dv_q, dv_d;
   logic        er_q, er_d;
   logic        rdy_q, rdy_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        uf_q, uf_d;

   logic        take;
   logic [31:0] crc_nxt;
   logic [31:0] fcs_sh;
   logic [7:0]  ifg_m;
   logic [8:0]  gap;

   crc32_nibble u_crc (
      .data_i (rxd_q),
      .crc_i  (crc_q),
      .crc_o  (crc_nxt)
   );

   assign fcs_sh = crc_q >> {cnt_q[2:0], 2'b00};
   assign ifg_m  = (cfg_ifg == 8'd0) ? 8'd1 : cfg_ifg;
   // The IDLE cycle before the next preamble counts toward the gap.
   assign gap    = {ifg_m, 1'b0} - 9'd1;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bytes_d = bytes_q;
      data_d  = data_q;
      last_d  = last_q;
      bad_d   = bad_q;
      hi_d    = hi_q;
      crc_d   = crc_q;
      rxd_d   = rxd_q;
      dv_d    = dv_q;
      er_d    = er_q;
      rdy_d   = rdy_q;
      done_d  = 1'b0;
      uf_d    = 1'b0;
      take    = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            crc_d   = CRC32_INIT;
            cnt_d   = '0;
            bytes_d = '0;
            hi_d    = 1'b0;
            rxd_d   = '0;
            dv_d    = 1'b0;
            er_d    = 1'b0;
            rdy_d   = 1'b0;
            if (s_axis_if.tvalid && cfg_enable) begin
               state_d = ST_PREAMBLE;
               rxd_d   = MII_PREAMBLE_NIBBLE;
               dv_d    = 1'b1;
               cnt_d   = 9'd1;
            end
         end
         ST_PREAMBLE: begin
            if (cnt_q >= PRE_LEN) begin
               state_d = ST_SFD;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 9'd1;
            end
         end
         ST_SFD: begin
            if (rdy_q) begin
               take = 1'b1;
            end else begin
               rxd_d = MII_SFD_HI;
               rdy_d = 1'b1;
            end
         end
         ST_DATA: begin
            crc_d = crc_nxt;
            if (!hi_q) begin
               hi_d  = 1'b1;
               rxd_d = data_q[7:4];
               er_d  = bad_q;
               rdy_d = !last_q;
            end else if (rdy_q) begin
               take = 1'b1;
            end else begin
               er_d = 1'b0;
               hi_d = 1'b0;
               if (ENABLE_PADDING && ({1'b0, bytes_q} < PAD_LEN)) begin
                  state_d = ST_PAD;
                  rxd_d   = '0;
               end else begin
                  state_d = ST_FCS;
                  rxd_d   = ~crc_nxt[3:0];
                  cnt_d   = 9'd1;
               end
            end
         end
         ST_PAD: begin
            crc_d = crc_nxt;
            rxd_d = '0;
            hi_d  = !hi_q;
            if (hi_q) begin
               bytes_d = bytes_q + 8'd1;
               if ({1'b0, bytes_q} + 9'd1 >= PAD_LEN) begin
                  state_d = ST_FCS;
                  rxd_d   = ~crc_nxt[3:0];
                  cnt_d   = 9'd1;
               end
            end
         end
         ST_FCS: begin
            if (cnt_q == 9'd8) begin
               state_d = ST_IFG;
               rxd_d   = '0;
               dv_d    = 1'b0;
               cnt_d   = gap;
            end else begin
               rxd_d  = ~fcs_sh[3:0];
               cnt_d  = cnt_q + 9'd1;
               done_d = (cnt_q == 9'd7);
            end
         end
         ST_IFG: begin
            if (cnt_q <= 9'd1) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - 9'd1;
            end
         end
         ST_DROP: begin
            rxd_d = '0;
            dv_d  = 1'b0;
            er_d  = 1'b0;
            if (s_axis_if.tvalid && rdy_q && s_axis_if.tlast) begin
               state_d = ST_IFG;
               rdy_d   = 1'b0;
               cnt_d   = gap;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // Byte fetch slot: capture the next byte or abort on a starved stream.
      if (take) begin
         rdy_d = 1'b0;
         hi_d  = 1'b0;
         if (s_axis_if.tvalid) begin
            state_d = ST_DATA;
            data_d  = s_axis_if.tdata[7:0];
            last_d  = s_axis_if.tlast;
            bad_d   = s_axis_if.tuser && s_axis_if.tlast;
            er_d    = s_axis_if.tuser && s_axis_if.tlast;
            rxd_d   = s_axis_if.tdata[3:0];
            bytes_d = (bytes_q == 8'hFF) ? bytes_q : bytes_q + 8'd1;
         end else begin
            state_d = ST_DROP;
            rxd_d   = '0;
            er_d    = 1'b1;
            uf_d    = 1'b1;
            done_d  = 1'b1;
            rdy_d   = 1'b1;
         end
      end
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         bytes_q <= '0;
         data_q  <= '0;
         last_q  <= 1'b0;
         bad_q   <= 1'b0;
         hi_q    <= 1'b0;
         crc_q   <= CRC32_INIT;
         rxd_q   <= '0;
         dv_q    <= 1'b0;
         er_q    <= 1'b0;
         rdy_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         uf_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bytes_q <= bytes_d;
         data_q  <= data_d;
         last_q  <= last_d;
         bad_q   <= bad_d;
         hi_q    <= hi_d;
         crc_q   <= crc_d;
         rxd_q   <= rxd_d;
         dv_q    <= dv_d;
         er_q    <= er_d;
         rdy_q   <= rdy_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         uf_q    <= uf_d;
      end
   end

   assign s_axis_if.tready = rdy_q;
   assign mii_rxd          = rxd_q;
   assign mii_rx_dv        = dv_q;
   assign mii_rx_er        = er_q;
   assign busy             = busy_q;
   assign frame_done       = done_q;
   assign underflow        = uf_q;

endmodule

// File: tb/tb_mii_phy_frame_source.sv
// Directed bench for mii_phy_frame_source: nibble stream, FCS,
// padding, gap, underflow, bad-frame and reset behaviour.
module tb_mii_phy_frame_source;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [7:0] cfg_ifg = 8'd12;
   logic       cfg_enable = 1'b1;
   logic       np_sel = 1'b0;
   logic       tv = 1'b0;
   logic [7:0] td = 8'h00;
   logic       tl = 1'b0;
   logic       tu = 1'b0;

   always #5 clk = ~clk;

   AXIS_IF #(.TDATA_WIDTH(8)) ax ();
   AXIS_IF #(.TDATA_WIDTH(8)) axn ();

   assign ax.tvalid  = tv & ~np_sel;
   assign ax.tdata   = td;
   assign ax.tlast   = tl;
   assign ax.tuser   = tu;
   assign axn.tvalid = tv & np_sel;
   assign axn.tdata  = td;
   assign axn.tlast  = tl;
   assign axn.tuser  = tu;

   logic [3:0] rxd_m, rxd_n;
   logic       dv_m, er_m, busy_m, done_m, uf_m;
   logic       dv_n, er_n, busy_n, done_n, uf_n;

   mii_phy_frame_source dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .s_axis_if  (ax),
      .mii_rxd    (rxd_m),
      .mii_rx_dv  (dv_m),
      .mii_rx_er  (er_m),
      .cfg_ifg    (cfg_ifg),
      .cfg_enable (cfg_enable),
      .busy       (busy_m),
      .frame_done (done_m),
      .underflow  (uf_m)
   );

   mii_phy_frame_source #(.ENABLE_PADDING(1'b0)) dut_np (
      .clk        (clk),
      .reset_n    (reset_n),
      .s_axis_if  (axn),
      .mii_rxd    (rxd_n),
      .mii_rx_dv  (dv_n),
      .mii_rx_er  (er_n),
      .cfg_ifg    (cfg_ifg),
      .cfg_enable (cfg_enable),
      .busy       (busy_n),
      .frame_done (done_n),
      .underflow  (uf_n)
   );

   wire [3:0] m_rxd  = np_sel ? rxd_n : rxd_m;
   wire       m_dv   = np_sel ? dv_n : dv_m;
   wire       m_er   = np_sel ? er_n : er_m;
   wire       m_done = np_sel ? done_n : done_m;
   wire       m_uf   = np_sel ? uf_n : uf_m;
   wire       m_rdy  = np_sel ? axn.tready : ax.tready;

   int errs = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   logic [4:0] cap[$];
   int         runs[$];
   int         gaps[$];
   int         cur_run = 0, cur_gap = 0;
   logic       prev_dv = 1'b0;
   int         n_done = 0, n_uf = 0;
   int         clr_req = 0, clr_ack = 0;

   always @(negedge clk) begin
      if (clr_req != clr_ack) begin
         cap.delete();
         runs.delete();
         gaps.delete();
         cur_run = 0;
         cur_gap = 0;
         n_done  = 0;
         n_uf    = 0;
         clr_ack = clr_req;
      end else begin
         if (m_dv) begin
            if (!prev_dv) gaps.push_back(cur_gap);
            cap.push_back({m_er, m_rxd});
            cur_run++;
            cur_gap = 0;
         end else begin
            if (prev_dv) runs.push_back(cur_run);
            cur_run = 0;
            cur_gap++;
         end
         if (m_done) n_done++;
         if (m_uf) n_uf++;
      end
      prev_dv = m_dv;
   end

   task automatic clr_mon();
      @(posedge clk);
      clr_req++;
      @(negedge clk);
      #1;
   endtask

   function automatic int run_len(input int k);
      return (runs.size() > k) ? runs[k] : -1;
   endfunction

   function automatic int gap_len(input int k);
      return (gaps.size() > k) ? gaps[k] : -1;
   endfunction

   function automatic int count_er(input int off, input int n);
      int c = 0;
      for (int i = off; i < off + n && i < cap.size(); i++)
         if (cap[i][4]) c++;
      return c;
   endfunction

   logic [7:0] fr[$];
   logic [3:0] expn[$];

   task automatic pre_exp();
      expn.delete();
      for (int i = 0; i < 15; i++) expn.push_back(4'h5);
      expn.push_back(4'h5);
      expn.push_back(4'hD);
   endtask

   // Independent byte-serial reference CRC over the padded frame.
   task automatic build_exp(input bit pad);
      logic [7:0]  pb[$];
      logic [31:0] crc, fcs, sh;
      pb = fr;
      if (pad) while (pb.size() < 60) pb.push_back(8'h00);
      pre_exp();
      crc = 32'hFFFFFFFF;
      foreach (pb[i]) begin
         expn.push_back(pb[i][3:0]);
         expn.push_back(pb[i][7:4]);
         crc = crc ^ {24'h0, pb[i]};
         for (int b = 0; b < 8; b++)
            crc = crc[0] ? ((crc >> 1) ^ 32'hEDB88320) : (crc >> 1);
      end
      fcs = ~crc;
      for (int k = 0; k < 8; k++) begin
         sh = fcs >> (4 * k);
         expn.push_back(sh[3:0]);
      end
   endtask

   task automatic cmp_frame(input string tag, input int off);
      int bad = 0;
      foreach (expn[i])
         if (off + i >= cap.size() || cap[off + i][3:0] !== expn[i]) bad++;
      check({tag, "_nibble_errs"}, 32'(bad), 0);
   endtask

   task automatic finish_now();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $fatal(1, "bench aborted");
   endtask

   task automatic wait_rdy();
      int t = 0;
      while (!m_rdy && t < 1000) begin
         @(negedge clk);
         t++;
      end
      check("tready_wait", 32'(t < 1000), 1);
      if (t >= 1000) finish_now();
      @(negedge clk);
   endtask

   task automatic send(input bit bad, input int uf_at, input bit keep);
      for (int i = 0; i < fr.size(); i++) begin
         if (uf_at > 0 && i == uf_at) begin
            tv = 1'b0;
            repeat (3) @(negedge clk);
         end
         tv = 1'b1;
         td = fr[i];
         tl = (i == fr.size() - 1);
         tu = bad && tl;
         wait_rdy();
      end
      if (!keep) begin
         tv = 1'b0;
         tl = 1'b0;
         tu = 1'b0;
      end
   endtask

   task automatic wait_done(input int n);
      int t = 0;
      while (n_done < n && t < 3000) begin
         @(negedge clk);
         t++;
      end
      check("frame_done_wait", 32'(n_done >= n), 1);
      if (n_done < n) finish_now();
      repeat (4) @(negedge clk);
   endtask

   task automatic make_frame(input int n, input int seed);
      fr.delete();
      for (int i = 0; i < n; i++) fr.push_back(8'(i * 7 + seed));
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check("rst_rxd", 32'(rxd_m), 0);
      check("rst_dv", 32'(dv_m), 0);
      check("rst_er", 32'(er_m), 0);
      check("rst_tready", 32'(ax.tready), 0);
      check("rst_busy", 32'(busy_m), 0);
      check("rst_done", 32'(done_m), 0);
      check("rst_uf", 32'(uf_m), 0);
      reset_n = 1'b1;
      @(negedge clk);

      np_sel = 1'b1;
      clr_mon();
      fr = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
      send(1'b0, 0, 1'b0);
      wait_done(1);
      pre_exp();
      foreach (fr[i]) begin
         expn.push_back(fr[i][3:0]);
         expn.push_back(fr[i][7:4]);
      end
      expn.push_back(4'h6); expn.push_back(4'h2);
      expn.push_back(4'h9); expn.push_back(4'h3);
      expn.push_back(4'h4); expn.push_back(4'hF);
      expn.push_back(4'hB); expn.push_back(4'hC);
      check("t1_dv_len", 32'(run_len(0)), 43);
      cmp_frame("t1", 0);
      check("t1_er", 32'(count_er(0, 43)), 0);
      check("t1_done_cnt", 32'(n_done), 1);
      np_sel = 1'b0;

      clr_mon();
      make_frame(14, 1);
      send(1'b0, 0, 1'b0);
      wait_done(1);
      build_exp(1'b1);
      check("t2_dv_len", 32'(run_len(0)), 145);
      cmp_frame("t2", 0);
      check("t2_er", 32'(count_er(0, 145)), 0);

      clr_mon();
      make_frame(60, 3);
      send(1'b0, 0, 1'b1);
      make_frame(60, 11);
      send(1'b0, 0, 1'b0);
      wait_done(2);
      build_exp(1'b1);
      check("t3_len_a", 32'(run_len(0)), 145);
      check("t3_len_b", 32'(run_len(1)), 145);
      check("t3_gap", 32'(gap_len(1)), 24);
      cmp_frame("t3b", 145);

      clr_mon();
      make_frame(60, 5);
      send(1'b0, 20, 1'b0);
      make_frame(10, 9);
      send(1'b0, 0, 1'b0);
      wait_done(2);
      check("t4_len_abort", 32'(run_len(0)), 58);
      check("t4_err_nibble", (cap.size() > 57) ? 32'(cap[57]) : 32'hFFFF, 32'h10);
      check("t4_er_cnt", 32'(count_er(0, 58)), 1);
      check("t4_uf_cnt", 32'(n_uf), 1);
      check("t4_gap_min", 32'(gap_len(1) >= 24), 1);
      check("t4_len_next", 32'(run_len(1)), 145);
      build_exp(1'b1);
      cmp_frame("t4b", 58);
      check("t4_er_next", 32'(count_er(58, 145)), 0);

      clr_mon();
      make_frame(64, 2);
      send(1'b1, 0, 1'b0);
      wait_done(1);
      build_exp(1'b1);
      check("t5_dv_len", 32'(run_len(0)), 153);
      cmp_frame("t5", 0);
      check("t5_er_cnt", 32'(count_er(0, 153)), 2);
      check("t5_er_lo", (cap.size() > 144) ? 32'(cap[143][4]) : 32'hFF, 1);
      check("t5_er_hi", (cap.size() > 144) ? 32'(cap[144][4]) : 32'hFF, 1);

      tv = 1'b1;
      td = 8'hA5;
      tl = 1'b0;
      tu = 1'b0;
      repeat (40) @(negedge clk);
      check("t6_dv_before", 32'(dv_m), 1);
      reset_n = 1'b0;
      tv = 1'b0;
      @(negedge clk);
      check("t6_dv", 32'(dv_m), 0);
      check("t6_busy", 32'(busy_m), 0);
      check("t6_tready", 32'(ax.tready), 0);
      check("t6_er", 32'(er_m), 0);
      reset_n = 1'b1;
      @(negedge clk);
      clr_mon();
      make_frame(14, 17);
      send(1'b0, 0, 1'b0);
      wait_done(1);
      build_exp(1'b1);
      check("t6_dv_len", 32'(run_len(0)), 145);
      cmp_frame("t6", 0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

   initial begin
      #3_000_000;
      check("global_timeout", 0, 1);
      finish_now();
   end

endmodule
